// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues one memory request at a time and
// parks the returned word in a single-entry buffer until decode takes it.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_FETCH | request outstanding at pc; waiting for MEM_IF_valid_i
// S_HOLD  | word buffered, offered to decode; no request
// S_FLUSH | redirected while a request was in flight; drain it, drop data
module instr_fetch #(
    parameter int unsigned        BITSIZE      = 32,
    parameter logic [BITSIZE-1:0] RESET_VECTOR = '0
) (
    input  logic               clk,
    input  logic               rst_i,
    output logic               IF_ID_give_o,
    input  logic               ID_IF_get_i,
    output logic [31:0]        IF_ID_instr_o,
    output logic [BITSIZE-1:0] IF_ID_pc_o,
    input  logic               EX_IF_branch_i,
    input  logic [BITSIZE-1:0] EX_IF_target_i,
    output logic               IF_MEM_req_o,
    output logic [BITSIZE-1:0] IF_MEM_addr_o,
    input  logic               MEM_IF_valid_i,
    input  logic [31:0]        MEM_IF_data_i,
    output logic               inv_addr_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t             r_state;
    logic [BITSIZE-1:0] r_pc;
    logic [BITSIZE-1:0] r_addr;
    logic [BITSIZE-1:0] r_pc_o;
    logic [31:0]        r_instr;
    logic               r_inv_addr;

    logic [BITSIZE-1:0] w_target_al;
    logic               w_target_mis;
    logic [BITSIZE-1:0] w_pc_next;

    assign w_target_al  = {EX_IF_target_i[BITSIZE-1:2], 2'b00};
    assign w_target_mis = |EX_IF_target_i[1:0];
    assign w_pc_next    = r_pc + BITSIZE'(4);

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_VECTOR;
            r_addr     <= RESET_VECTOR;
            r_pc_o     <= '0;
            r_instr    <= '0;
            r_inv_addr <= 1'b0;
        end else begin
            // A redirect wins over every other event in the same cycle.
            if (EX_IF_branch_i) begin
                r_pc <= w_target_al;
                if (w_target_mis) begin
                    r_inv_addr <= 1'b1;
                end
            end

            unique case (r_state)
                S_FETCH: begin
                    if (EX_IF_branch_i) begin
                        if (!MEM_IF_valid_i) begin
                            r_addr  <= r_pc;
                            r_state <= S_FLUSH;
                        end
                    end else if (MEM_IF_valid_i) begin
                        r_instr <= MEM_IF_data_i;
                        r_pc_o  <= w_pc_next;
                        r_pc    <= w_pc_next;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (EX_IF_branch_i || ID_IF_get_i) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FLUSH: begin
                    if (MEM_IF_valid_i) begin
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // FLUSH keeps presenting the stale address until the in-flight word drains.
    assign IF_MEM_req_o  = !rst_i && (r_state != S_HOLD);
    assign IF_MEM_addr_o = rst_i ? '0 : ((r_state == S_FLUSH) ? r_addr : r_pc);
    assign IF_ID_give_o  = !rst_i && (r_state == S_HOLD) && !EX_IF_branch_i;
    assign IF_ID_instr_o = rst_i ? '0 : r_instr;
    assign IF_ID_pc_o    = rst_i ? '0 : r_pc_o;
    assign inv_addr_o    = !rst_i && r_inv_addr;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed sequences, a redirect table, and a random
// phase scored against a "next instruction to deliver" model.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        give;
    logic        get;
    logic [31:0] instr;
    logic [31:0] pc_o;
    logic        br;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        inv;

    int n_checks = 0;
    int n_errors = 0;

    int          lat_fixed = 2;
    bit          lat_rand  = 0;
    bit          pending;
    int          cnt;
    int          cur_lat;
    logic [31:0] pend_addr;

    instr_fetch #(.BITSIZE(32), .RESET_VECTOR(32'h0)) dut (
        .clk            (clk),
        .rst_i          (rst),
        .IF_ID_give_o   (give),
        .ID_IF_get_i    (get),
        .IF_ID_instr_o  (instr),
        .IF_ID_pc_o     (pc_o),
        .EX_IF_branch_i (br),
        .EX_IF_target_i (tgt),
        .IF_MEM_req_o   (req),
        .IF_MEM_addr_o  (addr),
        .MEM_IF_valid_i (mem_valid),
        .MEM_IF_data_i  (mem_data),
        .inv_addr_o     (inv)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00500093;
        if (a == 32'h4) return 32'h00100113;
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic wait_give(input int max_cyc, input string nm);
        int n = 0;
        @(negedge clk);
        while (!give && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk1(nm, give, 1'b1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk1({nm, "_req"}, req, 1'b0);
        chk({nm, "_addr"}, addr, 32'h0);
        chk1({nm, "_give"}, give, 1'b0);
        chk({nm, "_instr"}, instr, 32'h0);
        chk({nm, "_pc_o"}, pc_o, 32'h0);
        chk1({nm, "_inv"}, inv, 1'b0);
    endtask

    // Memory: serves one request at a time after a configurable number of cycles,
    // and checks that the request stays up with a stable address until served.
    initial begin
        mem_valid = 1'b0;
        mem_data  = '0;
        pending   = 1'b0;
        cnt       = 0;
        cur_lat   = 0;
        pend_addr = '0;
        forever begin
            @(negedge clk);
            mem_valid = 1'b0;
            if (rst) begin
                pending = 1'b0;
                cnt     = 0;
            end else begin
                if (pending) chk1("req_hold", req, 1'b1);
                if (req) begin
                    if (!pending) begin
                        pending   = 1'b1;
                        cnt       = 0;
                        pend_addr = addr;
                        cur_lat   = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
                    end else begin
                        chk("req_addr_stable", addr, pend_addr);
                    end
                    if (cnt >= cur_lat) begin
                        mem_valid = 1'b1;
                        mem_data  = mem_word(addr);
                        pending   = 1'b0;
                    end else begin
                        cnt++;
                    end
                end else begin
                    pending = 1'b0;
                end
            end
        end
    end

    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc_o;
        logic        exp_inv;
    } vec_t;

    vec_t tbl[4];

    initial begin
        logic [31:0] i0;
        logic [31:0] p0;
        logic [31:0] model_pc;
        logic        model_inv;
        int          n8;
        int          gave;
        int          xfers;
        int          r;

        tbl[0] = '{32'h0000_0040, 32'h0000_0040, 32'h0000_0044, 1'b0};
        tbl[1] = '{32'h0000_0102, 32'h0000_0100, 32'h0000_0104, 1'b1};
        tbl[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
        tbl[3] = '{32'h0000_002F, 32'h0000_002C, 32'h0000_0030, 1'b1};

        rst = 1'b1; get = 1'b0; br = 1'b0; tgt = '0;

        // Reset state, then the first request at the reset vector.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0; get = 1'b1;
        @(negedge clk);
        chk1("first_req", req, 1'b1);
        chk("first_addr", addr, 32'h0);
        chk1("first_give", give, 1'b0);

        // Two-word stream with decode always ready.
        wait_give(20, "stream0_give");
        chk("stream0_instr", instr, 32'h00500093);
        chk("stream0_pc_o", pc_o, 32'h4);
        wait_give(20, "stream1_give");
        chk("stream1_instr", instr, 32'h00100113);
        chk("stream1_pc_o", pc_o, 32'h8);

        // Redirect while the request to 0x8 is still in flight.
        @(posedge clk); #1;
        lat_fixed = 4; br = 1'b1; tgt = 32'h80;
        @(negedge clk);
        chk1("flush_req", req, 1'b1);
        chk("flush_addr", addr, 32'h8);
        chk1("flush_give", give, 1'b0);
        @(posedge clk); #1;
        br = 1'b0; get = 1'b0;
        n8 = 0; gave = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (give) gave++;
            if (!(req && addr == 32'h8)) break;
            n8++;
        end
        chk("flush_stale_cycles", n8, 4);
        chk("flush_no_give", gave, 0);
        chk1("refetch_req", req, 1'b1);
        chk("refetch_addr", addr, 32'h80);
        lat_fixed = 2;
        wait_give(20, "refetch_give");
        chk("refetch_pc_o", pc_o, 32'h84);
        chk("refetch_instr", instr, mem_word(32'h80));

        // Backpressure: word held stable, no new request, then one transfer.
        i0 = instr; p0 = pc_o;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("bp_give", give, 1'b1);
            chk("bp_instr", instr, i0);
            chk("bp_pc_o", pc_o, p0);
            chk1("bp_req", req, 1'b0);
        end
        @(posedge clk); #1;
        get = 1'b1;
        @(negedge clk);
        chk1("bp_xfer_give", give, 1'b1);
        @(posedge clk); #1;
        get = 1'b0;
        @(negedge clk);
        chk1("bp_after_give", give, 1'b0);
        chk1("bp_after_req", req, 1'b1);
        chk("bp_after_addr", addr, 32'h84);
        wait_give(20, "bp_next_give");
        chk("bp_next_pc_o", pc_o, 32'h88);

        // Redirects taken while a word is buffered and decode is ready.
        foreach (tbl[k]) begin
            wait_give(20, "tbl_hold_give");
            @(posedge clk); #1;
            br = 1'b1; tgt = tbl[k].target; get = 1'b1;
            @(negedge clk);
            chk1("tbl_kill_give", give, 1'b0);
            @(posedge clk); #1;
            br = 1'b0; get = 1'b0;
            @(negedge clk);
            chk1("tbl_req", req, 1'b1);
            chk("tbl_addr", addr, tbl[k].exp_addr);
            chk1("tbl_inv", inv, tbl[k].exp_inv);
            wait_give(20, "tbl_give");
            chk("tbl_pc_o", pc_o, tbl[k].exp_pc_o);
            chk("tbl_instr", instr, mem_word(tbl[k].exp_addr));
        end

        // Reset in the middle of a fetch.
        @(posedge clk); #1;
        get = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        get = 1'b0;
        @(negedge clk);
        chk1("midrst_pre_req", req, 1'b1);
        chk("midrst_pre_addr", addr, 32'h30);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("restart_req", req, 1'b1);
        chk("restart_addr", addr, 32'h0);
        chk1("restart_inv", inv, 1'b0);
        wait_give(20, "restart_give");
        chk("restart_pc_o", pc_o, 32'h4);
        chk("restart_instr", instr, 32'h00500093);

        // Random traffic against the delivery model.
        lat_rand = 1;
        model_pc = 32'h0; model_inv = 1'b0; xfers = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            br = ($urandom_range(0, 9) == 0);
            r = int'($urandom_range(0, 7));
            if (r == 0)      tgt = 32'hFFFF_FFFC;
            else if (r == 1) tgt = $urandom;
            else             tgt = $urandom_range(0, 255) << 2;
            get = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            chk1("rnd_inv", inv, model_inv);
            if (br) chk1("rnd_kill", give, 1'b0);
            if (give && get) begin
                chk("rnd_instr", instr, mem_word(model_pc));
                chk("rnd_pc_o", pc_o, model_pc + 32'h4);
                model_pc = model_pc + 32'h4;
                xfers++;
            end
            if (br) begin
                model_pc = tgt & ~32'h3;
                if (tgt[1:0] != 2'b00) model_inv = 1'b1;
            end
        end
        br = 1'b0; get = 1'b0;
        chk1("rnd_progress", xfers >= 100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
